// File: rtl/tape_mem.sv
// Zero-initialised data memory at the far end of the load/store chain.
// One load (2-cycle latency, same-cycle store forwarded) and one store per cycle; a clear FSM sweeps the array.
module tape_mem #(
    parameter int ADDR_BITS = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        ld_en,
    input  logic [15:0] ld_addr,
    output logic [15:0] ld_data,
    output logic        ld_valid,
    input  logic        st_en,
    input  logic [15:0] st_addr,
    input  logic [15:0] st_data,
    output logic        mem_busy
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t                 state_reg, state_next;
    logic [ADDR_BITS-1:0]   clr_addr_reg, clr_addr_next;

    logic                   wr_en;
    logic [ADDR_BITS-1:0]   wr_addr;
    logic [15:0]            wr_data;
    logic                   rd_fire;
    logic                   fwd_hit;

    logic [15:0]            mem [DEPTH];
    logic                   v1_reg;
    logic [15:0]            d1_reg;

    // Upper address bits are intentionally ignored so addresses wrap modulo DEPTH.
    generate
        if (ADDR_BITS < 16) begin : g_addr_wrap
            logic unused_addr_bits;
            assign unused_addr_bits = ^{st_addr[15:ADDR_BITS], ld_addr[15:ADDR_BITS]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= CLEAR;
            clr_addr_reg <= '0;
        end else begin
            state_reg    <= state_next;
            clr_addr_reg <= clr_addr_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        clr_addr_next = clr_addr_reg;
        mem_busy      = 1'b0;
        wr_en         = 1'b0;
        wr_addr       = st_addr[ADDR_BITS-1:0];
        wr_data       = st_data;
        rd_fire       = 1'b0;
        case (state_reg)
            CLEAR: begin
                // Requests are dropped while sweeping; the sweep owns the write port.
                mem_busy = 1'b1;
                wr_en    = 1'b1;
                wr_addr  = clr_addr_reg;
                wr_data  = '0;
                if (clr_addr_reg == '1) begin
                    state_next    = READY;
                    clr_addr_next = '0;
                end else begin
                    clr_addr_next = clr_addr_reg + ADDR_BITS'(1);
                end
            end
            READY: begin
                wr_en   = st_en;
                rd_fire = ld_en;
                if (clear) begin
                    state_next = CLEAR;
                end
            end
            default: begin
                state_next = CLEAR;
            end
        endcase
    end

    assign fwd_hit = st_en && (st_addr[ADDR_BITS-1:0] == ld_addr[ADDR_BITS-1:0]);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Stage-1 data: a store in the same cycle wins over the array's old contents.
    always_ff @(posedge clk) begin
        if (rd_fire) begin
            d1_reg <= fwd_hit ? st_data : mem[ld_addr[ADDR_BITS-1:0]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_reg   <= 1'b0;
            ld_valid <= 1'b0;
            ld_data  <= 16'h0000;
        end else begin
            v1_reg   <= rd_fire;
            ld_valid <= v1_reg;
            if (v1_reg) begin
                ld_data <= d1_reg;
            end
        end
    end

endmodule

// File: tb/tb_tape_mem.sv
// Directed bench for tape_mem with a 16-word tape: clear sweep, load latency, forwarding, wrap, reset.
module tb_tape_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        ld_en;
    logic [15:0] ld_addr;
    logic [15:0] ld_data;
    logic        ld_valid;
    logic        st_en;
    logic [15:0] st_addr;
    logic [15:0] st_data;
    logic        mem_busy;

    int total = 0;
    int bad   = 0;
    int n;
    int seen;

    tape_mem #(.ADDR_BITS(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .ld_en    (ld_en),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .ld_valid (ld_valid),
        .st_en    (st_en),
        .st_addr  (st_addr),
        .st_data  (st_data),
        .mem_busy (mem_busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, got, exp);
    endtask

    // Counts cycles with mem_busy high from now on, and any ld_valid seen meanwhile.
    task automatic busy_count(output int cnt, output int valid_seen);
        cnt = 0;
        valid_seen = 0;
        while (mem_busy === 1'b1 && cnt < 100) begin
            if (ld_valid !== 1'b0) valid_seen++;
            cnt++;
            step();
        end
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; ld_en = 1'b0; ld_addr = '0;
        st_en = 1'b0; st_addr = '0; st_data = '0;
        step();
        step();
        check("rst_valid", {15'd0, ld_valid}, 16'd0);
        check("rst_data", ld_data, 16'h0000);
        check("rst_busy", {15'd0, mem_busy}, 16'd1);

        // Initial sweep length
        rst = 1'b0;
        busy_count(n, seen);
        check("init_busy_cyc", 16'(n), 16'd16);
        check("init_busy_off", {15'd0, mem_busy}, 16'd0);

        // Pipelined loads of every address: all zero
        for (int i = 0; i <= 16; i++) begin
            ld_en   = (i < 16);
            ld_addr = 16'(i);
            step();
            if (i >= 1) begin
                check("zero_valid", {15'd0, ld_valid}, 16'd1);
                check("zero_data", ld_data, 16'h0000);
            end
        end
        ld_en = 1'b0;
        step();
        check("idle_valid", {15'd0, ld_valid}, 16'd0);

        // Store addr 3 then load it the next cycle
        st_en = 1'b1; st_addr = 16'd3; st_data = 16'h00AB;
        step();
        st_en = 1'b0; ld_en = 1'b1; ld_addr = 16'd3;
        step();
        ld_en = 1'b0;
        check("st3_lat1", {15'd0, ld_valid}, 16'd0);
        step();
        check("st3_valid", {15'd0, ld_valid}, 16'd1);
        check("st3_data", ld_data, 16'h00AB);

        // Same-cycle load/store forwarding
        ld_en = 1'b1; ld_addr = 16'd5; st_en = 1'b1; st_addr = 16'd5; st_data = 16'h1234;
        step();
        ld_en = 1'b0; st_en = 1'b0;
        step();
        check("fwd_valid", {15'd0, ld_valid}, 16'd1);
        check("fwd_data", ld_data, 16'h1234);

        // Store one cycle after a load is not visible to it
        ld_en = 1'b1; ld_addr = 16'd7;
        step();
        ld_en = 1'b0; st_en = 1'b1; st_addr = 16'd7; st_data = 16'h0055;
        step();
        st_en = 1'b0;
        check("late_st_valid", {15'd0, ld_valid}, 16'd1);
        check("late_st_data", ld_data, 16'h0000);
        ld_en = 1'b1; ld_addr = 16'd7;
        step();
        ld_en = 1'b0;
        step();
        check("reload7_data", ld_data, 16'h0055);

        // Wrap-around addressing
        st_en = 1'b1; st_addr = 16'h0012; st_data = 16'h0042;
        step();
        st_en = 1'b0; ld_en = 1'b1; ld_addr = 16'h0002;
        step();
        ld_en = 1'b0;
        step();
        check("wrap_data", ld_data, 16'h0042);

        // Three back-to-back loads
        st_en = 1'b1; st_addr = 16'd8; st_data = 16'h1111;
        step();
        st_addr = 16'd9; st_data = 16'h2222;
        step();
        st_en = 1'b0; ld_en = 1'b1; ld_addr = 16'd8;
        step();
        ld_addr = 16'd9;
        step();
        ld_addr = 16'd3;
        check("b2b_v0", {15'd0, ld_valid}, 16'd1);
        check("b2b_d0", ld_data, 16'h1111);
        step();
        ld_en = 1'b0;
        check("b2b_d1", ld_data, 16'h2222);
        step();
        check("b2b_v2", {15'd0, ld_valid}, 16'd1);
        check("b2b_d2", ld_data, 16'h00AB);
        step();
        check("b2b_end_valid", {15'd0, ld_valid}, 16'd0);
        check("b2b_hold_data", ld_data, 16'h00AB);

        // Clear with a same-cycle load of addr 3; stores and loads during sweep dropped
        ld_data_prime();
        clear = 1'b1; ld_en = 1'b1; ld_addr = 16'd3;
        step();
        clear = 1'b0; ld_en = 1'b0;
        n = 0;
        seen = 0;
        while (mem_busy === 1'b1 && n < 100) begin
            n++;
            if (n == 2) begin
                check("clr_ld_valid", {15'd0, ld_valid}, 16'd1);
                check("clr_ld_data", ld_data, 16'h00AB);
            end
            if (n > 2 && ld_valid !== 1'b0) seen++;
            st_en = (n == 3); st_addr = 16'd1; st_data = 16'hBEEF;
            ld_en = (n == 5); ld_addr = 16'd1;
            step();
        end
        st_en = 1'b0; ld_en = 1'b0;
        check("clr_busy_cyc", 16'(n), 16'd16);
        check("clr_no_valid", 16'(seen), 16'd0);
        ld_en = 1'b1; ld_addr = 16'd3;
        step();
        ld_addr = 16'd1;
        step();
        ld_en = 1'b0;
        check("after_clr_a3", ld_data, 16'h0000);
        check("after_clr_a3v", {15'd0, ld_valid}, 16'd1);
        step();
        check("dropped_st_a1", ld_data, 16'h0000);

        // Reset with a load in flight
        st_en = 1'b1; st_addr = 16'd2; st_data = 16'h0077;
        step();
        st_en = 1'b0; ld_en = 1'b1; ld_addr = 16'd2;
        step();
        ld_en = 1'b0;
        step();
        check("pre_rst_data", ld_data, 16'h0077);
        clear = 1'b1; ld_en = 1'b1; ld_addr = 16'd2;
        step();
        clear = 1'b0; ld_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", {15'd0, ld_valid}, 16'd0);
        check("arst_data", ld_data, 16'h0000);
        step();
        step();
        rst = 1'b0;
        busy_count(n, seen);
        check("rst1_busy_cyc", 16'(n), 16'd16);
        check("rst1_no_stale", 16'(seen), 16'd0);

        // Reset five cycles into a sweep restarts it
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("mid_clr_busy", {15'd0, mem_busy}, 16'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", {15'd0, mem_busy}, 16'd1);
        step();
        rst = 1'b0;
        busy_count(n, seen);
        check("rst2_busy_cyc", 16'(n), 16'd16);
        ld_en = 1'b1; ld_addr = 16'd2;
        step();
        ld_en = 1'b0;
        step();
        check("final_a2_valid", {15'd0, ld_valid}, 16'd1);
        check("final_a2_data", ld_data, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Make ld_data nonzero before the clear test so its result is distinguishable.
    task automatic ld_data_prime();
        ld_en = 1'b1; ld_addr = 16'd8;
        step();
        ld_en = 1'b0;
        step();
        check("prime_data", ld_data, 16'h1111);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
